// File: rtl/iob_cpu_iob_bridge_pkg.sv
// iob_cpu_iob_bridge_pkg: shared FSM state type and channel-select width helper for the bridge
package iob_cpu_iob_bridge_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    function automatic int sel_w(input int n_dch);
        return n_dch > 1 ? $clog2(n_dch) : 0;
    endfunction

endpackage

// File: rtl/iob_cpu_iob_bridge_if.sv
// iob_cpu_iob_bridge_if: CPU native port, IOb instruction bus and N_DCH IOb data buses
// master: the bridge (accepts CPU requests, drives ibus/dbus requests)
// slave:  the environment (CPU plus the buses' targets)
interface iob_cpu_iob_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_DCH  = 2
);
    logic                      cpu_instr;
    logic                      cpu_valid;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic [DATA_W/8-1:0]       cpu_wstrb;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_ready;
    logic                      ibus_valid;
    logic [ADDR_W-1:0]         ibus_addr;
    logic                      ibus_ready;
    logic                      ibus_rvalid;
    logic [DATA_W-1:0]         ibus_rdata;
    logic [N_DCH-1:0]          dbus_valid;
    logic [ADDR_W-1:0]         dbus_addr;
    logic [DATA_W-1:0]         dbus_wdata;
    logic [DATA_W/8-1:0]       dbus_wstrb;
    logic [N_DCH-1:0]          dbus_ready;
    logic [N_DCH-1:0]          dbus_rvalid;
    logic [N_DCH*DATA_W-1:0]   dbus_rdata;

    modport master (
        input  cpu_instr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  ibus_ready, ibus_rvalid, ibus_rdata,
        input  dbus_ready, dbus_rvalid, dbus_rdata,
        output cpu_rdata, cpu_ready, ibus_valid, ibus_addr,
        output dbus_valid, dbus_addr, dbus_wdata, dbus_wstrb
    );

    modport slave (
        output cpu_instr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output ibus_ready, ibus_rvalid, ibus_rdata,
        output dbus_ready, dbus_rvalid, dbus_rdata,
        input  cpu_rdata, cpu_ready, ibus_valid, ibus_addr,
        input  dbus_valid, dbus_addr, dbus_wdata, dbus_wstrb
    );

endinterface

// File: rtl/iob_cpu_iob_bridge_wdog.sv
// iob_cpu_iob_bridge_wdog: read-response watchdog, limit 2**W-1 counted cycles
// Ports: clk, rst (sync, active-high), cke (state holds when low),
//        clr (restart count), en (count this cycle), hit (this counted cycle reaches the limit)
module iob_cpu_iob_bridge_wdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic cke,
    input  logic clr,
    input  logic en,
    output logic hit
);

    if (W > 0) begin : g_cnt
        logic [W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst || (cke && clr)) cnt <= '0;
            else if (cke && en) cnt <= cnt + 1'b1;
        end
        // cnt == limit-1 while counting means this cycle brings it to the limit
        assign hit = en && cnt == ~W'(1);
    end else begin : g_off
        assign hit = 1'b0;
    end

endmodule

// File: rtl/iob_cpu_iob_bridge.sv
// iob_cpu_iob_bridge: CPU valid/ready port to one IOb instruction bus and N_DCH decoded IOb data buses
// Ports: clk, rst (sync, active-high), cke (clock enable, freezes all state when low),
//        boot (ibus address remap when USE_EXTMEM), err (sticky read timeout), err_clr,
//        bus (master side of iob_cpu_iob_bridge_if)
module iob_cpu_iob_bridge
    import iob_cpu_iob_bridge_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                N_DCH      = 2,
    parameter int                TIMEOUT_W  = 8,
    parameter logic [DATA_W-1:0] ERR_RDATA  = 32'hDEADBEEF,
    parameter bit                USE_EXTMEM = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cke,
    input  logic                 boot,
    input  logic                 err_clr,
    output logic                 err,
    iob_cpu_iob_bridge_if.master bus
);

    localparam int SEL_W = sel_w(N_DCH);
    localparam int SW    = SEL_W > 0 ? SEL_W : 1;

    state_t              state;
    logic                instr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [SW-1:0]       sel;
    logic [SW-1:0]       sel_in;
    logic [DATA_W-1:0]   ch_rdata [N_DCH];
    logic                ready_sel;
    logic                rvalid_sel;
    logic                hit;

    for (genvar k = 0; k < N_DCH; k++) begin : g_ch
        assign ch_rdata[k] = bus.dbus_rdata[k*DATA_W +: DATA_W];
    end

    assign sel_in     = N_DCH > 1 ? bus.cpu_addr[ADDR_W-1 -: SW] : '0;
    assign ready_sel  = instr ? bus.ibus_ready  : bus.dbus_ready[sel];
    assign rvalid_sel = instr ? bus.ibus_rvalid : bus.dbus_rvalid[sel];

    assign bus.ibus_addr  = USE_EXTMEM ? {~boot, addr[ADDR_W-2:0]} : addr;
    assign bus.dbus_addr  = addr;
    assign bus.dbus_wdata = wdata;
    assign bus.dbus_wstrb = wstrb;

    iob_cpu_iob_bridge_wdog #(.W(TIMEOUT_W)) u_wdog (
        .clk (clk),
        .rst (rst),
        .cke (cke),
        .clr (state == REQ),
        .en  (state == WAIT_R && !rvalid_sel),
        .hit (hit)
    );

    // cpu_ready is set on the transition into DONE, so it is high exactly while in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            instr          <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            wstrb          <= '0;
            sel            <= '0;
            bus.ibus_valid <= 1'b0;
            bus.dbus_valid <= '0;
            bus.cpu_ready  <= 1'b0;
            bus.cpu_rdata  <= '0;
            err            <= 1'b0;
        end else if (cke) begin
            bus.cpu_ready <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                IDLE: if (bus.cpu_valid) begin
                    instr          <= bus.cpu_instr;
                    addr           <= bus.cpu_addr;
                    wdata          <= bus.cpu_wdata;
                    wstrb          <= bus.cpu_wstrb;
                    sel            <= sel_in;
                    bus.ibus_valid <= bus.cpu_instr;
                    bus.dbus_valid <= bus.cpu_instr ? '0 : N_DCH'(1) << sel_in;
                    state          <= REQ;
                end
                REQ: if (ready_sel) begin
                    bus.ibus_valid <= 1'b0;
                    bus.dbus_valid <= '0;
                    bus.cpu_ready  <= |wstrb;
                    state          <= |wstrb ? DONE : WAIT_R;
                end
                WAIT_R: if (rvalid_sel || hit) begin
                    bus.cpu_rdata <= rvalid_sel ? (instr ? bus.ibus_rdata : ch_rdata[sel]) : ERR_RDATA;
                    // a timeout overrides a same-cycle err_clr
                    if (!rvalid_sel) err <= 1'b1;
                    bus.cpu_ready <= 1'b1;
                    state         <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
